// File: rtl/store_lane_queue.sv
// Store-path queue between the MEM stage and the data-memory bus.
// Decodes sb/sh/sw/sd into lane-placed data and byte enables, flags misaligned
// stores, buffers accepted stores in a small FIFO (optionally coalescing
// same-word stores into the tail entry), and issues them on a valid/ready bus.
module store_lane_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int MERGE  = 1,
    localparam int NB    = DATA_W / 8,
    localparam int OB    = $clog2(NB),
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              align_err,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NB-1:0]     mem_byteen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CW-1:0]     count
);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [NB-1:0]     q_be   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     tail_ptr;

    logic [OB-1:0]     off;
    logic [1:0]        size_log;
    logic              legal;
    logic              misaligned;
    logic [NB-1:0]     be_mask;
    logic [DATA_W-1:0] data_mask;
    logic [NB-1:0]     new_be;
    logic [DATA_W-1:0] new_data;
    logic [ADDR_W-1:0] word_addr;

    logic              full;
    logic              enq;
    logic              merge;
    logic              push;
    logic              pop;
    logic              err_hit;

    // Decode the request size, alignment and the lane-placed data/byte enables.
    always_comb begin
        off       = in_addr[OB-1:0];
        size_log  = 2'd0;
        legal     = 1'b0;
        case (in_op)
            3'b001: begin size_log = 2'd0; legal = 1'b1; end
            3'b010: begin size_log = 2'd1; legal = 1'b1; end
            3'b011: begin size_log = 2'd2; legal = 1'b1; end
            3'b100: begin size_log = 2'd3; legal = (DATA_W == 64); end
            default: begin size_log = 2'd0; legal = 1'b0; end
        endcase
        // Any offset bit below the size exponent makes the access misaligned.
        misaligned = 1'b0;
        for (int k = 0; k < OB; k++) begin
            if (off[k] && (k < int'(size_log))) misaligned = 1'b1;
        end
        be_mask = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < (int'(1) << size_log)) be_mask[j] = 1'b1;
        end
        data_mask = '0;
        for (int j = 0; j < NB; j++) begin
            data_mask[8*j +: 8] = {8{be_mask[j]}};
        end
        new_be    = be_mask << off;
        new_data  = (in_data & data_mask) << {off, 3'b000};
        word_addr = {in_addr[ADDR_W-1:OB], {OB{1'b0}}};
    end

    // Queue status and handshake qualifiers, all derived from registered state
    // on the bus side so nothing on in_* reaches mem_* combinationally.
    always_comb begin
        full     = (count == CW'(DEPTH));
        in_ready = !full;
        tail_ptr = wr_ptr - PW'(1);
        err_hit  = in_valid && legal && misaligned;
        enq      = in_valid && in_ready && legal && !misaligned && !flush;
        // Merging needs at least two entries so the head is never modified.
        merge    = (MERGE != 0) && enq && (count >= CW'(2)) &&
                   (q_addr[tail_ptr] == word_addr);
        push     = enq && !merge;
        mem_valid  = (count != '0);
        pop        = mem_valid && mem_ready;
        mem_addr   = q_addr[rd_ptr];
        mem_byteen = q_be[rd_ptr];
        mem_wdata  = q_data[rd_ptr];
    end

    // Pointers, occupancy and the alignment-error report; flush wins over traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            align_err <= 1'b0;
            err_addr  <= '0;
        end else begin
            align_err <= err_hit;
            if (err_hit) err_addr <= in_addr;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage: new stores land at wr_ptr, merges patch only new lanes of the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= word_addr;
            q_be[wr_ptr]   <= new_be;
            q_data[wr_ptr] <= new_data;
        end else if (merge) begin
            q_be[tail_ptr] <= q_be[tail_ptr] | new_be;
            for (int i = 0; i < NB; i++) begin
                if (new_be[i]) q_data[tail_ptr][8*i +: 8] <= new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_store_lane_queue.sv
// Directed self-checking bench for store_lane_queue: a 32-bit instance with
// merging for queue behaviour and a 64-bit instance for sd/lane placement.
module tb_store_lane_queue;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_SB   = 3'b001;
    localparam logic [2:0] OP_SH   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_SD   = 3'b100;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        align_err;
    logic [31:0] err_addr;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic [2:0]  count;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [2:0]  w_in_op;
    logic [31:0] w_in_addr;
    logic [63:0] w_in_data;
    logic        w_align_err;
    logic [31:0] w_err_addr;
    logic        w_flush;
    logic        w_mem_valid;
    logic        w_mem_ready;
    logic [31:0] w_mem_addr;
    logic [7:0]  w_mem_byteen;
    logic [63:0] w_mem_wdata;
    logic [2:0]  w_count;

    int assert_count = 0;
    int fail_count   = 0;

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    store_lane_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MERGE(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_data(in_data),
        .align_err(align_err), .err_addr(err_addr), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .count(count)
    );

    store_lane_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .MERGE(1)) dut_wide (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
        .in_addr(w_in_addr), .in_data(w_in_data),
        .align_err(w_align_err), .err_addr(w_err_addr), .flush(w_flush),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
        .mem_byteen(w_mem_byteen), .mem_wdata(w_mem_wdata), .count(w_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of the 32-bit request port, then settle just past the edge.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic fl);
        @(negedge clk);
        in_valid = v;
        in_op    = op;
        in_addr  = addr;
        in_data  = data;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of the 64-bit request port.
    task automatic applyWide(input logic v, input logic [2:0] op,
                             input logic [31:0] addr, input logic [63:0] data);
        @(negedge clk);
        w_in_valid = v;
        w_in_op    = op;
        w_in_addr  = addr;
        w_in_data  = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0; in_op = OP_NONE; in_addr = '0; in_data = '0;
        flush     = 1'b0; mem_ready = 1'b0;
        w_in_valid = 1'b0; w_in_op = OP_NONE; w_in_addr = '0; w_in_data = '0;
        w_flush    = 1'b0; w_mem_ready = 1'b1;

        #3;
        checkOutput("rst_count",     64'(count),     64'd0);
        checkOutput("rst_mem_valid", 64'(mem_valid), 64'd0);
        checkOutput("rst_align_err", 64'(align_err), 64'd0);
        checkOutput("rst_err_addr",  64'(err_addr),  64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic sw with an always-ready bus.
        mem_ready = 1'b1;
        applyStimulus(1'b1, OP_SW, 32'h1000, 32'h11223344, 1'b0);
        checkOutput("sw_valid",  64'(mem_valid),  64'd1);
        checkOutput("sw_addr",   64'(mem_addr),   64'h1000);
        checkOutput("sw_byteen", 64'(mem_byteen), 64'hF);
        checkOutput("sw_wdata",  64'(mem_wdata),  64'h11223344);
        checkOutput("sw_count",  64'(count),      64'd1);
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        checkOutput("sw_drained", 64'(count),     64'd0);
        checkOutput("sw_novalid", 64'(mem_valid), 64'd0);

        // Merge: blocker at head, sb then sh to the same word.
        mem_ready = 1'b0;
        applyStimulus(1'b1, OP_SW, 32'h5000, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, OP_SB, 32'h2003, 32'h000000AB, 1'b0);
        checkOutput("mrg_count_pre", 64'(count), 64'd2);
        applyStimulus(1'b1, OP_SH, 32'h2000, 32'h0000CDEF, 1'b0);
        checkOutput("mrg_count",     64'(count),    64'd2);
        checkOutput("mrg_head_addr", 64'(mem_addr), 64'h5000);
        mem_ready = 1'b1;
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        mem_ready = 1'b0;
        checkOutput("mrg_addr",   64'(mem_addr),   64'h2000);
        checkOutput("mrg_byteen", 64'(mem_byteen), 64'hB);
        checkOutput("mrg_wdata",  64'(mem_wdata),  64'hAB00CDEF);
        checkOutput("mrg_count1", 64'(count),      64'd1);
        mem_ready = 1'b1;
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        mem_ready = 1'b0;
        checkOutput("mrg_empty", 64'(count), 64'd0);

        // Same word as the only (head) entry must not merge.
        applyStimulus(1'b1, OP_SB, 32'h6000, 32'h00000011, 1'b0);
        applyStimulus(1'b1, OP_SB, 32'h6001, 32'h00000022, 1'b0);
        checkOutput("nohead_count",  64'(count),      64'd2);
        checkOutput("nohead_byteen", 64'(mem_byteen), 64'h1);
        checkOutput("nohead_wdata",  64'(mem_wdata),  64'h11);

        // Misaligned stores: one pulse each, back-to-back pulses stay high.
        applyStimulus(1'b1, OP_SH, 32'h3001, 32'h0000FFFF, 1'b0);
        checkOutput("mis_err",   64'(align_err), 64'd1);
        checkOutput("mis_addr",  64'(err_addr),  64'h3001);
        checkOutput("mis_count", 64'(count),     64'd2);
        applyStimulus(1'b1, OP_SW, 32'h3002, 32'h12345678, 1'b0);
        checkOutput("mis2_err",  64'(align_err), 64'd1);
        checkOutput("mis2_addr", 64'(err_addr),  64'h3002);
        applyStimulus(1'b1, OP_SW, 32'h3006, 32'h12345678, 1'b0);
        checkOutput("mis3_addr", 64'(err_addr),  64'h3006);
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        checkOutput("mis_clear", 64'(align_err), 64'd0);
        checkOutput("mis_hold",  64'(err_addr),  64'h3006);
        checkOutput("mis_count2", 64'(count),    64'd2);

        // Flush with count=3 and a same-cycle valid enqueue.
        applyStimulus(1'b1, OP_SW, 32'h7000, 32'hAAAA5555, 1'b0);
        checkOutput("fl_count_pre", 64'(count), 64'd3);
        applyStimulus(1'b1, OP_SW, 32'h7004, 32'hBBBB6666, 1'b1);
        checkOutput("fl_count", 64'(count),     64'd0);
        checkOutput("fl_valid", 64'(mem_valid), 64'd0);

        // Advance pointers by two so the fill below wraps.
        mem_ready = 1'b1;
        applyStimulus(1'b1, OP_SW, 32'h8000, 32'h00000008, 1'b0);
        checkOutput("adv_head0", 64'(mem_addr), 64'h8000);
        applyStimulus(1'b1, OP_SW, 32'h8004, 32'h00000009, 1'b0);
        checkOutput("adv_count", 64'(count),    64'd1);
        checkOutput("adv_head1", 64'(mem_addr), 64'h8004);
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        checkOutput("adv_empty", 64'(count), 64'd0);

        // Fill to DEPTH with a stalled bus, then drain in order.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, OP_SW, 32'h9000 + 32'(4 * i), 32'(i + 1), 1'b0);
        end
        checkOutput("full_count", 64'(count),    64'd4);
        checkOutput("full_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, OP_SW, 32'h9010, 32'h00000005, 1'b0);
        checkOutput("full_ignored", 64'(count),     64'd4);
        checkOutput("full_head",    64'(mem_addr),  64'h9000);
        checkOutput("full_hdata",   64'(mem_wdata), 64'd1);
        mem_ready = 1'b1;
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        checkOutput("deq_ready", 64'(in_ready), 64'd1);
        checkOutput("deq_count", 64'(count),    64'd3);
        for (int i = 1; i < 4; i++) begin
            checkOutput("order_addr", 64'(mem_addr),  64'(32'h9000 + 32'(4 * i)));
            checkOutput("order_data", 64'(mem_wdata), 64'(i + 1));
            applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        end
        checkOutput("drain_count", 64'(count), 64'd0);

        // Asynchronous reset in the middle of operation.
        mem_ready = 1'b0;
        applyStimulus(1'b1, OP_SW, 32'hA000, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
        checkOutput("mid_count_pre", 64'(count), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_count",    64'(count),     64'd0);
        checkOutput("mid_valid",    64'(mem_valid), 64'd0);
        checkOutput("mid_err_addr", 64'(err_addr),  64'd0);
        checkOutput("mid_ready",    64'(in_ready),  64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // 64-bit instance: sd, upper-half sw, byte lane, misaligned sd.
        applyWide(1'b1, OP_SD, 32'h4000, 64'h01020304_05060708);
        checkOutput("w_sd_byteen", 64'(w_mem_byteen), 64'hFF);
        checkOutput("w_sd_wdata",  w_mem_wdata,       64'h01020304_05060708);
        checkOutput("w_sd_addr",   64'(w_mem_addr),   64'h4000);
        applyWide(1'b1, OP_SW, 32'h4004, 64'hFFFFFFFF_55667788);
        checkOutput("w_sw_byteen", 64'(w_mem_byteen), 64'hF0);
        checkOutput("w_sw_wdata",  w_mem_wdata,       64'h55667788_00000000);
        checkOutput("w_sw_addr",   64'(w_mem_addr),   64'h4000);
        applyWide(1'b1, OP_SB, 32'h4005, 64'h00000000_0000009A);
        checkOutput("w_sb_byteen", 64'(w_mem_byteen), 64'h20);
        checkOutput("w_sb_wdata",  w_mem_wdata,       64'h00009A00_00000000);
        applyWide(1'b1, OP_SD, 32'h4004, 64'h11111111_11111111);
        checkOutput("w_mis_err",   64'(w_align_err), 64'd1);
        checkOutput("w_mis_addr",  64'(w_err_addr),  64'h4004);
        checkOutput("w_mis_count", 64'(w_count),     64'd0);
        applyWide(1'b0, OP_NONE, 32'h0, 64'h0);
        checkOutput("w_mis_clear", 64'(w_align_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
